// File: rtl/lb_seq_pkg.sv
// Shared definitions for the local-bus script sequencer: FSM states,
// reserved script codes and readback buffer defaults.
package lb_seq_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      EXEC  = 3'd2,
      GAP   = 3'd3,
      STALL = 3'd4,
      READ  = 3'd5,
      DRAIN = 3'd6,
      DONE  = 3'd7
   } seq_state_t;

   localparam int STALL_CODE = 555;
   localparam int BUF_BASE   = 81920;
   localparam int BUF_LEN    = 1024;
   localparam int IDX_W      = 10;
   // Local-bus read latency from lb_read to lb_out.
   localparam int READ_LAT   = 2;

endpackage

// File: rtl/lb_script_sequencer_if.sv
// Script ROM, local-bus and readout signals of the sequencer; master is the
// sequencer side, slave the ROM/bus/consumer side.
interface lb_seq_if #(
   parameter int aw = 17,
   parameter int sw = 6
);
   import lb_seq_pkg::*;

   logic [sw-1:0]    script_addr;
   logic [aw-1:0]    script_a;
   logic [31:0]      script_d;
   logic             script_last;
   logic [aw-1:0]    lb_addr;
   logic [31:0]      lb_data;
   logic             lb_write;
   logic             lb_read;
   logic [31:0]      lb_out;
   logic [31:0]      rd_data;
   logic [IDX_W-1:0] rd_index;
   logic             rd_valid;

   modport master (
      output script_addr, lb_addr, lb_data, lb_write, lb_read,
             rd_data, rd_index, rd_valid,
      input  script_a, script_d, script_last, lb_out
   );

   modport slave (
      input  script_addr, lb_addr, lb_data, lb_write, lb_read,
             rd_data, rd_index, rd_valid,
      output script_a, script_d, script_last, lb_out
   );

endinterface

// File: rtl/lb_read_align.sv
// Delays the read strobe and its buffer index so they line up with the
// local-bus read data returning a fixed number of cycles later.
module lb_read_align
   import lb_seq_pkg::*;
#(
   parameter int depth = READ_LAT,
   parameter int tw    = IDX_W
) (
   input  logic          lb_clk,
   input  logic          rst,
   input  logic          in_valid,
   input  logic [tw-1:0] in_tag,
   output logic          out_valid,
   output logic [tw-1:0] out_tag
);

   logic [depth-1:0] valid_q;
   logic [tw-1:0]    tag_q [depth];

   always_ff @(posedge lb_clk) begin
      if (rst) begin
         valid_q <= '0;
         for (int i = 0; i < depth; i++) tag_q[i] <= '0;
      end else begin
         valid_q[0] <= in_valid;
         tag_q[0]   <= in_tag;
         for (int i = 1; i < depth; i++) begin
            valid_q[i] <= valid_q[i-1];
            tag_q[i]   <= tag_q[i-1];
         end
      end
   end

   assign out_valid = valid_q[depth-1];
   assign out_tag   = tag_q[depth-1];

endmodule

// File: rtl/lb_script_sequencer.sv
// Walks a script ROM issuing paced local-bus writes and stalls, then reads
// back the waveform buffer and streams the words out with their index.
//
//   state | meaning
//   IDLE  | waiting for start
//   FETCH | script_addr presented to the ROM
//   EXEC  | ROM entry decoded: write strobe or stall load
//   GAP   | write pacing hold
//   STALL | down-counting the stall value
//   READ  | one lb_read per cycle across the buffer
//   DRAIN | waiting for the last reads to return
//   DONE  | completion pulse
module lb_script_sequencer
   import lb_seq_pkg::*;
#(
   parameter int aw         = 17,
   parameter int sw         = 6,
   parameter int stall_code = STALL_CODE,
   parameter int write_gap  = 3,
   parameter int buf_base   = BUF_BASE,
   parameter int buf_len    = BUF_LEN
) (
   input  logic   lb_clk,
   input  logic   rst,
   input  logic   start,
   lb_seq_if.master bus,
   output logic   busy,
   output logic   done
);

   seq_state_t       state_q, state_d;
   logic [sw-1:0]    ptr_q, ptr_d;
   logic             last_q, last_d;
   logic [31:0]      cnt_q, cnt_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [IDX_W-1:0] tag_q, tag_d;
   logic [aw-1:0]    lb_addr_q, addr_d;
   logic [31:0]      lb_data_q, data_d;
   logic             lb_write_q, write_d;
   logic             lb_read_q, read_d;
   logic [31:0]      rd_data_q;
   logic             entry_done;
   logic             align_valid;
   logic [IDX_W-1:0] align_tag;

   always_ff @(posedge lb_clk) begin
      if (rst) begin
         state_q    <= IDLE;
         ptr_q      <= '0;
         last_q     <= 1'b0;
         cnt_q      <= '0;
         idx_q      <= '0;
         tag_q      <= '0;
         lb_addr_q  <= '0;
         lb_data_q  <= '0;
         lb_write_q <= 1'b0;
         lb_read_q  <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         last_q     <= last_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         tag_q      <= tag_d;
         lb_addr_q  <= addr_d;
         lb_data_q  <= data_d;
         lb_write_q <= write_d;
         lb_read_q  <= read_d;
         rd_data_q  <= bus.rd_data;
      end
   end

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      last_d     = last_q;
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      tag_d      = tag_q;
      addr_d     = lb_addr_q;
      data_d     = lb_data_q;
      write_d    = 1'b0;
      read_d     = 1'b0;
      entry_done = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               ptr_d   = '0;
               state_d = FETCH;
            end
         end
         FETCH: state_d = EXEC;
         EXEC: begin
            last_d = bus.script_last;
            if (bus.script_a == aw'(stall_code)) begin
               cnt_d   = bus.script_d;
               state_d = STALL;
            end else begin
               write_d = 1'b1;
               addr_d  = bus.script_a;
               data_d  = bus.script_d;
               // FETCH and EXEC already account for two cycles of the pacing.
               if (write_gap > 2) begin
                  cnt_d   = 32'(write_gap - 3);
                  state_d = GAP;
               end else begin
                  entry_done = 1'b1;
               end
            end
         end
         GAP, STALL: begin
            if (cnt_q == '0) entry_done = 1'b1;
            else             cnt_d = cnt_q - 32'd1;
         end
         READ: begin
            read_d = 1'b1;
            addr_d = aw'(buf_base) + aw'(idx_q);
            tag_d  = idx_q;
            if (idx_q == IDX_W'(buf_len - 1)) begin
               cnt_d   = 32'(READ_LAT - 1);
               state_d = DRAIN;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         DRAIN: begin
            if (cnt_q == '0) state_d = DONE;
            else             cnt_d = cnt_q - 32'd1;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Running off the end of the ROM without a last flag ends the script.
      if (entry_done) begin
         if (last_d || ptr_q == '1) begin
            idx_d   = '0;
            state_d = READ;
         end else begin
            ptr_d   = ptr_q + 1'b1;
            state_d = FETCH;
         end
      end
   end

   lb_read_align #(
      .depth (READ_LAT),
      .tw    (IDX_W)
   ) u_read_align (
      .lb_clk    (lb_clk),
      .rst       (rst),
      .in_valid  (lb_read_q),
      .in_tag    (tag_q),
      .out_valid (align_valid),
      .out_tag   (align_tag)
   );

   assign bus.script_addr = ptr_q;
   assign bus.lb_addr     = lb_addr_q;
   assign bus.lb_data     = lb_data_q;
   assign bus.lb_write    = lb_write_q;
   assign bus.lb_read     = lb_read_q;
   assign bus.rd_valid    = align_valid;
   assign bus.rd_index    = align_tag;
   assign bus.rd_data     = align_valid ? bus.lb_out : rd_data_q;
   assign busy            = (state_q != IDLE);
   assign done            = (state_q == DONE);

endmodule

// File: tb/tb_lb_script_sequencer.sv
// Scoreboard bench for lb_script_sequencer: a script-level timing model
// queues expected writes, reads, readout words and done pulses.
module tb_lb_script_sequencer;

   localparam int SW = 3;
   localparam int NE = 8;
   localparam int BL = 8;
   localparam int WG = 3;
   localparam int BB = 81920;
   localparam int SC = 555;

   typedef struct {
      int          cyc;
      logic [31:0] a;
      logic [31:0] d;
   } ev_t;

   logic lb_clk = 1'b0;
   logic rst    = 1'b1;
   logic start  = 1'b0;
   logic busy, done;
   int   cyc    = 0;
   int   n_checks = 0;
   int   n_errors = 0;
   int   busy_lo  = 1;
   int   busy_hi  = 0;
   bit   mon_en   = 1'b0;

   logic [16:0] rom_a    [NE];
   logic [31:0] rom_d    [NE];
   logic        rom_last [NE];

   ev_t q_wr[$];
   ev_t q_rs[$];
   ev_t q_rv[$];
   ev_t q_dn[$];

   lb_seq_if #(.aw(17), .sw(SW)) bus ();

   lb_script_sequencer #(.aw(17), .sw(SW), .write_gap(WG), .buf_len(BL)) dut (
      .lb_clk (lb_clk),
      .rst    (rst),
      .start  (start),
      .bus    (bus),
      .busy   (busy),
      .done   (done)
   );

   always #5 lb_clk = ~lb_clk;
   always @(posedge lb_clk) cyc <= cyc + 1;

   // Registered script ROM and a local bus whose read data equals the address.
   logic        p1v = 1'b0, p2v = 1'b0;
   logic [31:0] p1 = '0, p2 = '0;
   always @(posedge lb_clk) begin
      bus.script_a    <= rom_a[bus.script_addr];
      bus.script_d    <= rom_d[bus.script_addr];
      bus.script_last <= rom_last[bus.script_addr];
      p1v <= bus.lb_read;
      p1  <= 32'(bus.lb_addr);
      p2v <= p1v;
      p2  <= p1;
   end
   assign bus.lb_out = p2v ? p2 : 32'hdead_beef;

   task automatic chk(input string name, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic cmp_ev(input string name, input bit have, input ev_t e,
                         input logic [31:0] a, input logic [31:0] d);
      if (!have) begin
         n_checks++;
         n_errors++;
         $display("FAIL %s_unexpected: got event a=%0d d=%0d expected none (cycle %0d)", name, a, d, cyc);
      end else begin
         chk({name, "_cycle"}, cyc, e.cyc);
         chk({name, "_a"}, a, e.a);
         chk({name, "_d"}, d, e.d);
      end
   endtask

   ev_t         m_ev;
   bit          m_have;
   bit          skip_hold = 1'b1;
   logic [16:0] prev_addr = '0;
   logic [31:0] prev_data = '0;

   always @(negedge lb_clk) begin
      if (mon_en) begin
         chk("wr_rd_excl", longint'(bus.lb_write & bus.lb_read), 0);
         chk("busy", longint'(busy), longint'(cyc >= busy_lo && cyc <= busy_hi));
         if (!bus.lb_write && !bus.lb_read && !skip_hold) begin
            chk("addr_hold", bus.lb_addr, prev_addr);
            chk("data_hold", bus.lb_data, prev_data);
         end
         if (bus.lb_write) begin
            m_have = q_wr.size() > 0;
            m_ev   = m_have ? q_wr.pop_front() : '{0, 0, 0};
            cmp_ev("write", m_have, m_ev, 32'(bus.lb_addr), bus.lb_data);
         end
         if (bus.lb_read) begin
            m_have = q_rs.size() > 0;
            m_ev   = m_have ? q_rs.pop_front() : '{0, 0, 0};
            cmp_ev("read", m_have, m_ev, 32'(bus.lb_addr), 32'd0);
         end
         if (bus.rd_valid) begin
            m_have = q_rv.size() > 0;
            m_ev   = m_have ? q_rv.pop_front() : '{0, 0, 0};
            cmp_ev("rdout", m_have, m_ev, bus.rd_data, 32'(bus.rd_index));
         end
         if (done) begin
            m_have = q_dn.size() > 0;
            m_ev   = m_have ? q_dn.pop_front() : '{0, 0, 0};
            cmp_ev("done", m_have, m_ev, 32'd0, 32'd0);
         end
      end
      prev_addr = bus.lb_addr;
      prev_data = bus.lb_data;
      skip_hold = rst;
   end

   // Cycles from the start pulse to the first READ cycle, from the script rules.
   function automatic int read_offset();
      int t = 1;
      for (int i = 0; i < NE; i++) begin
         if (rom_a[i] == 17'(SC)) t += int'(rom_d[i]) + 3;
         else                     t += WG;
         if (rom_last[i]) break;
      end
      return t;
   endfunction

   task automatic goto(input int c);
      while (cyc < c) begin
         @(posedge lb_clk);
         #1;
      end
   endtask

   // Pulses start and queues every event due no later than cycle cut.
   task automatic issue(input int cut, output int t_dn);
      int s = cyc;
      int t = s + 1;
      for (int i = 0; i < NE; i++) begin
         if (rom_a[i] == 17'(SC)) begin
            t += int'(rom_d[i]) + 3;
         end else begin
            if (t + 2 <= cut) q_wr.push_back('{t + 2, 32'(rom_a[i]), rom_d[i]});
            t += WG;
         end
         if (rom_last[i]) break;
      end
      for (int i = 0; i < BL; i++) begin
         if (t + 1 + i <= cut) q_rs.push_back('{t + 1 + i, 32'(BB + i), 32'd0});
         if (t + 3 + i <= cut) q_rv.push_back('{t + 3 + i, 32'(BB + i), 32'(i)});
      end
      t_dn = t + BL + 2;
      if (t_dn <= cut) q_dn.push_back('{t_dn, 32'd0, 32'd0});
      busy_lo = s + 1;
      busy_hi = (t_dn <= cut) ? t_dn : cut;
      start = 1'b1;
      @(posedge lb_clk);
      #1;
      start = 1'b0;
   endtask

   task automatic settle(input int t_end, input string tag);
      goto(t_end + 4);
      chk({tag, "_wr_left"}, q_wr.size(), 0);
      chk({tag, "_rd_left"}, q_rs.size(), 0);
      chk({tag, "_rv_left"}, q_rv.size(), 0);
      chk({tag, "_done_left"}, q_dn.size(), 0);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_script_addr"}, bus.script_addr, 0);
      chk({tag, "_lb_addr"}, bus.lb_addr, 0);
      chk({tag, "_lb_data"}, bus.lb_data, 0);
      chk({tag, "_lb_write"}, bus.lb_write, 0);
      chk({tag, "_lb_read"}, bus.lb_read, 0);
      chk({tag, "_rd_data"}, bus.rd_data, 0);
      chk({tag, "_rd_index"}, bus.rd_index, 0);
      chk({tag, "_rd_valid"}, bus.rd_valid, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
   endtask

   task automatic clear_rom();
      for (int i = 0; i < NE; i++) begin
         rom_a[i]    = 17'(i + 100);
         rom_d[i]    = 32'(i);
         rom_last[i] = 1'b0;
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   initial begin
      int t_dn;
      int c;
      int len;
      clear_rom();
      repeat (3) @(posedge lb_clk);
      #1;
      rst = 1'b0;
      check_zero("reset");
      mon_en = 1'b1;

      // two writes 3 cycles apart, then readback
      clear_rom();
      rom_a[0] = 17'd10; rom_d[0] = 32'd5;
      rom_a[1] = 17'd11; rom_d[1] = 32'd7; rom_last[1] = 1'b1;
      issue(1 << 30, t_dn);
      settle(t_dn, "two_writes");

      // stall of 20, then a single write
      clear_rom();
      rom_a[0] = 17'(SC); rom_d[0] = 32'd20;
      rom_a[1] = 17'd12;  rom_d[1] = 32'd1; rom_last[1] = 1'b1;
      issue(1 << 30, t_dn);
      settle(t_dn, "stall20");

      // start re-pulsed during the stall must not disturb timing
      c = cyc;
      issue(1 << 30, t_dn);
      goto(c + 10);
      start = 1'b1;
      @(posedge lb_clk);
      #1;
      start = 1'b0;
      settle(t_dn, "stall_restart");

      // zero-length stall
      clear_rom();
      rom_a[0] = 17'(SC); rom_d[0] = 32'd0;
      rom_a[1] = 17'd77;  rom_d[1] = 32'hcafe; rom_last[1] = 1'b1;
      issue(1 << 30, t_dn);
      settle(t_dn, "stall0");

      // no last flag: eight writes, pointer wrap forces readback
      for (int i = 0; i < NE; i++) begin
         rom_a[i]    = 17'(200 + i);
         rom_d[i]    = 32'(1000 + i);
         rom_last[i] = 1'b0;
      end
      issue(1 << 30, t_dn);
      settle(t_dn, "overrun");

      // reset while reading word 3, then a clean rerun
      clear_rom();
      rom_a[0] = 17'd300; rom_d[0] = 32'd9; rom_last[0] = 1'b1;
      c = cyc + read_offset() + 4;
      issue(c, t_dn);
      goto(c);
      rst = 1'b1;
      @(posedge lb_clk);
      #1;
      check_zero("mid_read_rst");
      rst = 1'b0;
      settle(c + 6, "mid_read_rst");
      issue(1 << 30, t_dn);
      settle(t_dn, "rerun");

      // start coincident with reset is ignored
      rst   = 1'b1;
      start = 1'b1;
      @(posedge lb_clk);
      #1;
      rst   = 1'b0;
      start = 1'b0;
      @(posedge lb_clk);
      #1;
      chk("rst_start_busy", busy, 0);
      settle(cyc, "rst_start");

      // random scripts
      for (int k = 0; k < 20; k++) begin
         len = $urandom_range(1, NE);
         for (int i = 0; i < NE; i++) begin
            if ($urandom_range(0, 3) == 0) begin
               rom_a[i] = 17'(SC);
               rom_d[i] = 32'($urandom_range(0, 6));
            end else begin
               rom_a[i] = 17'($urandom_range(0, 131071));
               if (rom_a[i] == 17'(SC)) rom_a[i] = 17'(SC + 1);
               rom_d[i] = $urandom;
            end
            rom_last[i] = (i == len - 1);
         end
         issue(1 << 30, t_dn);
         settle(t_dn, "random");
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/lb_script_sequencer.md
LB_SCRIPT_SEQUENCER -- requirements
Module: lb_script_sequencer

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- aw, 17, local-bus address width
- sw, 6, script ROM address width
- stall_code, 555, script address value meaning "stall"
- write_gap, 3, minimum cycles between lb_write pulses
- buf_base, 81920, first waveform-buffer read address
- buf_len, 1024, number of buffer words read back
REQ-002 Ports SHALL be (name, direction, width, meaning):
- lb_clk, in, 1, single clock
- rst, in, 1, synchronous active-high reset
- start, in, 1, one-cycle pulse that begins a sequence
- script_addr, out, sw, external script ROM address
- script_a, in, aw, ROM entry address field, valid one cycle after script_addr
- script_d, in, 32, ROM entry data field
- script_last, in, 1, marks final ROM entry
- lb_addr, out, aw, local-bus address
- lb_data, out, 32, local-bus write data
- lb_write, out, 1, write strobe
- lb_read, out, 1, read strobe
- lb_out, in, 32, read result, valid exactly 2 cycles after lb_read
- rd_data, out, 32, captured readout word
- rd_index, out, 10, buffer index of rd_data
- rd_valid, out, 1, rd_data/rd_index qualifier
- busy, out, 1, sequence in progress
- done, out, 1, one-cycle completion pulse

Function
REQ-003 The FSM SHALL have states IDLE, FETCH, EXEC, GAP, STALL, READ, DRAIN, DONE.
REQ-004 In IDLE, start SHALL clear the ROM pointer to 0 and go to FETCH; start while busy SHALL be ignored.
REQ-005 FETCH SHALL present script_addr for one cycle; EXEC SHALL use the script_a/script_d/script_last values on the following cycle.
REQ-006 EXEC with script_a != stall_code SHALL drive lb_write=1 for exactly one cycle with lb_addr=script_a and lb_data=script_d, then enter GAP.
REQ-007 GAP SHALL hold write_gap-2 cycles so consecutive lb_write pulses are exactly write_gap cycles apart (FETCH, EXEC, GAP...).
REQ-008 EXEC with script_a == stall_code SHALL load a 32-bit counter with script_d and enter STALL; no bus strobe SHALL be issued.
REQ-009 STALL SHALL decrement once per cycle and exit when the counter is 0; script_d=0 SHALL exit after one cycle.
REQ-010 After the entry flagged script_last completes (write gap or stall), the FSM SHALL enter READ; otherwise the pointer SHALL increment and the FSM SHALL return to FETCH.
REQ-011 Pointer wrap from 2^sw-1 to 0 without script_last SHALL force READ (script overrun guard).
REQ-012 READ SHALL drive lb_read=1 on buf_len consecutive cycles with lb_addr=buf_base+i, i=0..buf_len-1.
REQ-013 A 2-stage read-tag pipeline SHALL align each lb_read with lb_out: rd_valid=1, rd_data=lb_out, rd_index=i, two cycles after the corresponding lb_read.
REQ-014 DRAIN SHALL last 2 cycles, collecting the final two words; DONE SHALL pulse done=1 for one cycle, then return to IDLE.
REQ-015 busy SHALL be 1 in every state except IDLE.
REQ-016 lb_write and lb_read SHALL never be asserted in the same cycle.
REQ-017 lb_addr and lb_data SHALL hold their last values when no strobe is asserted.

Reset
REQ-018 rst SHALL force IDLE on the next edge with all outputs 0 (script_addr, lb_addr, lb_data, lb_write, lb_read, rd_data, rd_index, rd_valid, busy, done).
REQ-019 rst mid-READ SHALL discard in-flight read tags; no rd_valid SHALL appear after reset.
REQ-020 start asserted together with rst SHALL be ignored.

Structure
REQ-021 State encodings, stall_code, and the buf_base/buf_len defaults SHALL live in a shared lb_seq_pkg.
REQ-022 The read-tag alignment pipeline SHALL be a sub-module, lb_read_align (depth parameter, default 2).

Verification
REQ-023 Script {(10,5),(11,7),last} with start -> lb_write at cycles t and t+3 with addr/data 10/5 then 11/7, followed by READ.
REQ-024 Script {(555,20),(12,1),last} -> no strobe for 20+ cycles, then a single write of 12/1.
REQ-025 buf_len=8, lb_out model returning the address -> rd_index 0..7 with rd_data=81920..81927, rd_valid 2 cycles after each lb_read, done 2 cycles after the last lb_read.
REQ-026 rst asserted at READ word 3 -> all outputs 0 the next cycle, no further rd_valid; a new start runs cleanly from script entry 0.
REQ-027 start re-pulsed during STALL -> ignored; write timing identical to REQ-024.
REQ-028 Script with no script_last and sw=3 -> 8 writes, wrap, then forced READ.
